// File: rtl/sprite_position_gen.sv
// sprite_position_gen
// Accumulates player movement commands into a pending (x, y) position,
// saturating each axis at the screen edges, and commits that position to a
// frame-stable packed output on every frame tick. The CPU therefore never
// sees a position that changes mid-frame.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   move_valid   movement command present this cycle
//   move_dir     0 = up (y-), 1 = down (y+), 2 = left (x-), 3 = right (x+)
//   move_step    distance in pixels, 0..255
//   move_ready   command can be accepted (low during frame_tick and reset)
//   frame_tick   one-cycle commit strobe at vertical-blank start
//   out_position committed position, [31:16] = y, [15:0] = x
//   clamped      some accepted move in the committed frame hit an edge
//   commit_pulse high for the cycle in which out_position was updated
module sprite_position_gen #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic [7:0]  move_step,
  output logic        move_ready,
  input  logic        frame_tick,
  output logic [31:0] out_position,
  output logic        clamped,
  output logic        commit_pulse
);

  localparam logic [15:0] XMAX16  = 16'(X_MAX);
  localparam logic [15:0] YMAX16  = 16'(Y_MAX);
  localparam logic [16:0] XMAX17  = 17'(X_MAX);
  localparam logic [16:0] YMAX17  = 17'(Y_MAX);
  localparam logic [15:0] XINIT16 = 16'(X_INIT);
  localparam logic [15:0] YINIT16 = 16'(Y_INIT);

  typedef enum logic {ACCUM, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] x_pend, y_pend, x_nxt, y_nxt;
  logic        clamp_pend, hit, accept;
  logic [16:0] sum_x, sum_y, step17;

  // A tick owns the cycle: the command waits so it lands in the next frame.
  assign move_ready = ~frame_tick & ~reset;
  assign accept     = move_valid & move_ready;

  // COMMIT lasts exactly the cycle after a sampled tick, which is the cycle
  // the committed registers hold their new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = ACCUM;
    if (frame_tick) state_nxt = COMMIT;
  end

  assign commit_pulse = (state == COMMIT);

  // Saturating move; 17-bit sums so the add can never wrap.
  always_comb begin
    x_nxt  = x_pend;
    y_nxt  = y_pend;
    hit    = 1'b0;
    step17 = {9'd0, move_step};
    sum_x  = {1'b0, x_pend} + step17;
    sum_y  = {1'b0, y_pend} + step17;
    case (move_dir)
      2'd0: begin
        if (step17 > {1'b0, y_pend}) begin y_nxt = '0; hit = 1'b1; end
        else y_nxt = y_pend - {8'd0, move_step};
      end
      2'd1: begin
        if (sum_y > YMAX17) begin y_nxt = YMAX16; hit = 1'b1; end
        else y_nxt = sum_y[15:0];
      end
      2'd2: begin
        if (step17 > {1'b0, x_pend}) begin x_nxt = '0; hit = 1'b1; end
        else x_nxt = x_pend - {8'd0, move_step};
      end
      default: begin
        if (sum_x > XMAX17) begin x_nxt = XMAX16; hit = 1'b1; end
        else x_nxt = sum_x[15:0];
      end
    endcase
  end

  // Pending position survives a commit so motion continues from the
  // committed point; only the per-frame edge flag restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pend       <= XINIT16;
      y_pend       <= YINIT16;
      clamp_pend   <= 1'b0;
      out_position <= {YINIT16, XINIT16};
      clamped      <= 1'b0;
    end else if (frame_tick) begin
      out_position <= {y_pend, x_pend};
      clamped      <= clamp_pend;
      clamp_pend   <= 1'b0;
    end else if (accept) begin
      x_pend     <= x_nxt;
      y_pend     <= y_nxt;
      clamp_pend <= clamp_pend | hit;
    end
  end

endmodule

// File: tb/tb_sprite_position_gen.sv
module tb_sprite_position_gen;
  localparam int XM = 639, YM = 479, XI = 320, YI = 240;

  logic        clk = 1'b0;
  logic        reset, move_valid, frame_tick, move_ready, clamped, commit_pulse;
  logic [1:0]  move_dir;
  logic [7:0]  move_step;
  logic [31:0] out_position;

  sprite_position_gen #(.X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_dir(move_dir),
    .move_step(move_step), .move_ready(move_ready), .frame_tick(frame_tick),
    .out_position(out_position), .clamped(clamped), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer screen coordinates.
  int mx, my, ox, oy;
  bit mcl, ocl, opulse;
  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int y, input int x);
    logic [15:0] y16, x16;
    y16 = 16'(y);
    x16 = 16'(x);
    return {y16, x16};
  endfunction

  task automatic model_reset();
    mx = XI; my = YI; mcl = 0;
    ox = XI; oy = YI; ocl = 0; opulse = 0;
  endtask

  task automatic model_move(input bit [1:0] d, input int s);
    case (d)
      2'd0: begin my = my - s; if (my < 0)  begin my = 0;  mcl = 1; end end
      2'd1: begin my = my + s; if (my > YM) begin my = YM; mcl = 1; end end
      2'd2: begin mx = mx - s; if (mx < 0)  begin mx = 0;  mcl = 1; end end
      default: begin mx = mx + s; if (mx > XM) begin mx = XM; mcl = 1; end end
    endcase
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".pos"},   out_position, pack(oy, ox));
    check({tag, ".clamp"}, {31'd0, clamped}, {31'd0, ocl});
    check({tag, ".pulse"}, {31'd0, commit_pulse}, {31'd0, opulse});
  endtask

  // One clock: drive at negedge, step model at posedge, check at next negedge.
  task automatic cyc(input string tag, input bit v, input bit [1:0] d, input int s, input bit t);
    move_valid = v; move_dir = d; move_step = 8'(s); frame_tick = t;
    #1;
    check({tag, ".ready"}, {31'd0, move_ready}, {31'd0, !t});
    @(posedge clk);
    opulse = t;
    if (t) begin ox = mx; oy = my; ocl = mcl; mcl = 0; end
    else if (v) model_move(d, s);
    @(negedge clk);
    move_valid = 0; frame_tick = 0;
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    model_reset();
    check({tag, ".rst_ready"}, {31'd0, move_ready}, 32'd0);
    check_outs({tag, ".rst"});
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; move_valid = 0; frame_tick = 0; move_dir = 0; move_step = 0;
    model_reset();
    @(negedge clk);
    do_reset("reset");
    check("reset.init_pos", out_position, 32'h00F0_0140);
    cyc("idle", 0, 0, 0, 0);

    // commit timing
    cyc("r10", 1, 3, 10, 0);
    cyc("d5", 1, 1, 5, 0);
    check("pre_tick_pos", out_position, 32'h00F0_0140);
    cyc("tick1", 0, 0, 0, 1);
    check("commit_pos", out_position, 32'h00F5_014A);
    cyc("after_tick", 0, 0, 0, 0);

    // saturation right/down
    do_reset("rst2");
    cyc("r255a", 1, 3, 255, 0);
    cyc("r255b", 1, 3, 255, 0);
    cyc("d255", 1, 1, 255, 0);
    cyc("tick2", 0, 0, 0, 1);
    check("sat_rd_pos", out_position, 32'h01DF_027F);
    check("sat_rd_clamp", {31'd0, clamped}, 32'd1);
    cyc("tick3", 0, 0, 0, 1);
    check("sat_rd_clear", {31'd0, clamped}, 32'd0);

    // saturation left/up
    do_reset("rst3");
    cyc("l200a", 1, 2, 200, 0);
    cyc("l200b", 1, 2, 200, 0);
    cyc("u240", 1, 0, 240, 0);
    cyc("u240b", 1, 0, 240, 0);
    cyc("tick4", 0, 0, 0, 1);
    check("sat_lu_pos", out_position, 32'h0000_0000);
    check("sat_lu_clamp", {31'd0, clamped}, 32'd1);
    cyc("l0", 1, 2, 0, 0);
    cyc("tick5", 0, 0, 0, 1);
    check("l0_clamp", {31'd0, clamped}, 32'd0);

    // exact edge landing from (0,0)
    cyc("r255", 1, 3, 255, 0);
    cyc("r255", 1, 3, 255, 0);
    cyc("r129", 1, 3, 129, 0);
    cyc("d255", 1, 1, 255, 0);
    cyc("d224", 1, 1, 224, 0);
    cyc("tick6", 0, 0, 0, 1);
    check("edge_pos", out_position, 32'h01DF_027F);
    check("edge_clamp", {31'd0, clamped}, 32'd0);

    // collision: command held across the tick
    cyc("coll", 1, 2, 9, 1);
    cyc("coll_held", 1, 2, 9, 0);
    check("coll_pos_same", out_position, 32'h01DF_027F);
    cyc("tick7", 0, 0, 0, 1);
    check("coll_pos", out_position, 32'h01DF_0276);

    // consecutive ticks
    cyc("tt1", 0, 0, 0, 1);
    cyc("tt2", 0, 0, 0, 1);

    // reset between move and tick
    cyc("pre_rst_move", 1, 3, 50, 0);
    do_reset("rst_mid");
    cyc("post_rst", 0, 0, 0, 0);
    check("rst_mid_pulse", {31'd0, commit_pulse}, 32'd0);
    cyc("tick8", 0, 0, 0, 1);
    check("rst_mid_pos", out_position, 32'h00F0_0140);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      cyc("rnd", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
          $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
